// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared definitions for the data-memory responder: FSM state encoding,
//   word geometry, the default base address, and a helper that expands
//   byte-lane strobes into a 64-bit bit mask.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES        = 8;
  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

  function automatic logic [63:0] lane_mask(input logic [7:0] wmask);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{wmask[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response bundle between a load/store initiator and the memory
//   responder.
//   Request : req_valid, req_ready, req_write, req_addr, req_wdata, req_wmask
//   Response: resp_valid, resp_ready, resp_rdata, resp_err
//   master = initiator side, slave = responder side.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_resp_array.sv
// mem_resp_array
//   DEPTH x 64-bit storage with one synchronous byte-masked write port and
//   one combinational read port sharing the same index. Contents are not
//   reset.
//   clock : write clock
//   we    : write enable for this cycle
//   idx   : word index for both read and write
//   wdata : lane-aligned write data
//   wmask : byte-lane strobes, bit i -> wdata[8i+7:8i]
//   rdata : current contents of word idx
module mem_resp_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [63:0]              wdata,
  input  logic [7:0]               wmask,
  output logic [63:0]              rdata
);

  logic [63:0] mem [DEPTH];
  logic [63:0] bit_mask;

  assign bit_mask = lane_mask(wmask);

  always_ff @(posedge clock) begin
    if (we) begin
      mem[idx] <= (mem[idx] & ~bit_mask) | (wdata & bit_mask);
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Target side of the core's data-memory interface. Accepts one read or
//   write per transaction, commits masked writes / samples read data when
//   entering RESP, and holds the response until the initiator takes it.
//   clock   : single rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : request/response bundle (slave side)
//
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   BUSY  | request latched, latency counter running
//   RESP  | resp_valid high, waiting for resp_ready
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic           clock,
  input  logic           reset_n,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [63:0] SPAN  = 64'(DEPTH * WORD_BYTES);
  // LATENCY 0 and 1 both respond the cycle after acceptance, so they skip BUSY.
  localparam bit          DIRECT_RESP = (LATENCY <= 1);
  localparam logic [3:0]  LAT_INIT    = DIRECT_RESP ? 4'd0 : 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        hold_write_q;
  logic [63:0] hold_addr_q;
  logic [63:0] hold_wdata_q;
  logic [7:0]  hold_wmask_q;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        commit;
  logic        op_write;
  logic [63:0] op_addr;
  logic [63:0] op_wdata;
  logic [7:0]  op_wmask;
  logic [63:0] op_offset;
  logic        op_in_range;
  logic [IDX_W-1:0] op_idx;
  logic [63:0] array_rdata;

  assign bus.req_ready  = reset_n && (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign accept = bus.req_valid && bus.req_ready;

  // Commit on the edge into RESP. On a direct IDLE->RESP hop the request
  // has not been latched yet, so the live bus fields are used instead.
  assign commit = ((state_q == ST_BUSY) && (cnt_q <= 4'd1)) ||
                  ((state_q == ST_IDLE) && accept && DIRECT_RESP);

  always_comb begin
    if (state_q == ST_IDLE) begin
      op_write = bus.req_write;
      op_addr  = bus.req_addr;
      op_wdata = bus.req_wdata;
      op_wmask = bus.req_wmask;
    end else begin
      op_write = hold_write_q;
      op_addr  = hold_addr_q;
      op_wdata = hold_wdata_q;
      op_wmask = hold_wmask_q;
    end
  end

  // 64-bit subtraction: addresses below the base wrap to huge offsets and
  // therefore fall out of range.
  assign op_offset   = op_addr - BASE_ADDR;
  assign op_in_range = (op_offset < SPAN);
  assign op_idx      = op_offset[IDX_W+2:3];

  mem_resp_array #(.DEPTH(DEPTH)) u_array (
    .clock (clock),
    .we    (commit && op_write && op_in_range),
    .idx   (op_idx),
    .wdata (op_wdata),
    .wmask (op_wmask),
    .rdata (array_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (DIRECT_RESP) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = LAT_INIT;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (commit) begin
      err_d   = !op_in_range;
      rdata_d = (op_write || !op_in_range) ? 64'd0 : array_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_write_q <= 1'b0;
      hold_addr_q  <= 64'd0;
      hold_wdata_q <= 64'd0;
      hold_wmask_q <= 8'd0;
    end else if (accept) begin
      hold_write_q <= bus.req_write;
      hold_addr_q  <= bus.req_addr;
      hold_wdata_q <= bus.req_wdata;
      hold_wmask_q <= bus.req_wmask;
    end
  end

endmodule
